bin_window_buffer_b4: RTL and testbench



---
 rtl/bin_window_buffer_b4.sv | 235 +++++++++++++++++++++++
 tb/tb_bin_window_buffer_b4.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_window_buffer_b4.sv
// bin_window_buffer_b4
// Ping-pong frame buffer that stores binary channel vectors from the block-3
// stage and replays each completed frame as overlapping KERNEL-vector windows
// (advancing STRIDE vectors per window) over a ready/valid handshake.
module bin_window_buffer_b4 #(
  parameter int CH        = 32,
  parameter int KERNEL    = 7,
  parameter int STRIDE    = 2,
  parameter int FRAME_LEN = 64,
  parameter int ADDR_W    = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CH-1:0]        bin_in,
  input  logic                 bin_in_val,
  output logic [CH*KERNEL-1:0] win_out,
  output logic                 win_val,
  input  logic                 win_ready,
  output logic                 win_last,
  output logic                 frame_done,
  output logic                 overflow_err
);

  localparam int NWIN  = (FRAME_LEN - KERNEL) / STRIDE + 1;
  localparam int IDX_W = (NWIN > 1) ? $clog2(NWIN) : 1;
  localparam int CMAX  = (KERNEL > STRIDE) ? KERNEL : STRIDE;
  localparam int CNT_W = $clog2(CMAX + 1);
  localparam int WIN_W = CH * KERNEL;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_EMIT  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Frame storage: one array per bank, synchronous read.
  logic [CH-1:0]     mem0 [FRAME_LEN];
  logic [CH-1:0]     mem1 [FRAME_LEN];

  logic [1:0]        full;
  logic [1:0]        full_next;
  logic              wr_bank;
  logic [ADDR_W-1:0] wr_ptr;
  logic              wr_full_eff;
  logic              wr_en;
  logic              wr_wrap;

  logic              rd_bank;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_issue;
  logic              rd_vld;
  logic [CH-1:0]     rd_data;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  win_idx;

  state_t            state;
  state_t            state_next;
  logic              accept;
  logic              is_last;
  logic              done_clr;
  logic [WIN_W+CH-1:0] shift_ext;

  assign accept    = (state == ST_EMIT) && win_ready;
  assign is_last   = (win_idx == IDX_W'(NWIN - 1));
  assign done_clr  = (state == ST_DONE);
  assign shift_ext = {rd_data, win_out};

  // Write admission: a bank being released this cycle already counts as empty.
  always_comb begin
    wr_full_eff = full[wr_bank] & ~(done_clr & (rd_bank == wr_bank));
    wr_en       = bin_in_val & ~wr_full_eff;
    wr_wrap     = wr_en & (wr_ptr == ADDR_W'(FRAME_LEN - 1));
  end

  // Full-flag update: release by the reader wins over completion by the writer.
  always_comb begin
    full_next = full;
    for (int b = 0; b < 2; b++) begin
      if (done_clr && (rd_bank == 1'(b))) begin
        full_next[b] = 1'b0;
      end else if (wr_wrap && (wr_bank == 1'(b))) begin
        full_next[b] = 1'b1;
      end else begin
        full_next[b] = full[b];
      end
    end
  end

  // Writer state: pointer, active bank, full flags and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      wr_bank      <= 1'b0;
      full         <= 2'b00;
      overflow_err <= 1'b0;
    end else begin
      full <= full_next;
      if (wr_wrap) begin
        wr_ptr  <= '0;
        wr_bank <= ~wr_bank;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (bin_in_val && wr_full_eff) begin
        overflow_err <= 1'b1;
      end
    end
  end

  // Bank RAMs: write port from the producer, 1-cycle read port for the reader.
  always_ff @(posedge clk) begin
    if (wr_en && !wr_bank) begin
      mem0[wr_ptr] <= bin_in;
    end
    if (wr_en && wr_bank) begin
      mem1[wr_ptr] <= bin_in;
    end
    if (rd_issue) begin
      rd_data <= rd_bank ? mem1[rd_addr] : mem0[rd_addr];
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Read FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (full[rd_bank]) state_next = ST_FILL;
                else               state_next = ST_IDLE;
      ST_FILL:  if (cnt == CNT_W'(KERNEL)) state_next = ST_EMIT;
                else                       state_next = ST_FILL;
      ST_EMIT:  if (accept) state_next = is_last ? ST_DONE : ST_SHIFT;
                else        state_next = ST_EMIT;
      ST_SHIFT: if (cnt == CNT_W'(STRIDE)) state_next = ST_EMIT;
                else                       state_next = ST_SHIFT;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Read FSM outputs: RAM read strobe and address. IDLE issues address 0
  // so the first window is ready one cycle earlier.
  always_comb begin
    rd_issue = 1'b0;
    rd_addr  = rd_ptr;
    case (state)
      ST_IDLE: begin
        rd_issue = full[rd_bank];
        rd_addr  = '0;
      end
      ST_FILL:  rd_issue = (cnt < CNT_W'(KERNEL));
      ST_SHIFT: rd_issue = (cnt < CNT_W'(STRIDE));
      default:  rd_issue = 1'b0;
    endcase
  end

  // Reader bookkeeping: read pointer, per-phase read count, window index, bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      cnt     <= '0;
      win_idx <= '0;
      rd_bank <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (full[rd_bank]) begin
            rd_ptr  <= ADDR_W'(1);
            cnt     <= CNT_W'(1);
            win_idx <= '0;
          end
        end
        ST_FILL, ST_SHIFT: begin
          if (rd_issue) begin
            rd_ptr <= rd_ptr + ADDR_W'(1);
            cnt    <= cnt + CNT_W'(1);
          end
        end
        ST_EMIT: begin
          if (accept) begin
            cnt <= '0;
            if (!is_last) begin
              win_idx <= win_idx + IDX_W'(1);
            end
          end
        end
        ST_DONE: begin
          rd_bank <= ~rd_bank;
          rd_ptr  <= '0;
        end
        default: begin
          rd_ptr <= '0;
        end
      endcase
    end
  end

  // Window shift register: each returned word enters at the top, oldest at bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld  <= 1'b0;
      win_out <= '0;
    end else begin
      rd_vld <= rd_issue;
      if (rd_vld) begin
        win_out <= shift_ext[WIN_W+CH-1:CH];
      end
    end
  end

  // Registered handshake outputs derived from the upcoming FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_val    <= 1'b0;
      win_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      win_val    <= (state_next == ST_EMIT);
      win_last   <= (state_next == ST_EMIT) && is_last;
      frame_done <= (state_next == ST_DONE);
    end
  end

endmodule

// File: tb/tb_bin_window_buffer_b4.sv
// Testbench for bin_window_buffer_b4: default configuration plus a small
// KERNEL=1/STRIDE=1/FRAME_LEN=4 instance. Expected windows are built from
// the list of accepted input vectors using the windowing rule directly.
module tb_bin_window_buffer_b4;

  localparam int CH = 32;
  localparam int K  = 7;
  localparam int S  = 2;
  localparam int F  = 64;
  localparam int NW = (F - K) / S + 1;
  localparam int WW = CH * K;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] bin_in = '0;
  logic          bin_in_val = 1'b0;
  logic          win_ready = 1'b0;
  logic [WW-1:0] win_out;
  logic          win_val, win_last, frame_done, overflow_err;

  logic [CH-1:0] s_bin_in = '0;
  logic          s_val = 1'b0;
  logic          s_ready = 1'b0;
  logic [CH-1:0] s_win_out;
  logic          s_win_val, s_win_last, s_frame_done, s_ovf;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_wr_cyc = 0;
  int first_val_cyc = -1;
  int fd_cnt = 0;
  logic [CH-1:0] sent [$];

  bin_window_buffer_b4 u_dut (
    .clk(clk), .rst_n(rst_n), .bin_in(bin_in), .bin_in_val(bin_in_val),
    .win_out(win_out), .win_val(win_val), .win_ready(win_ready),
    .win_last(win_last), .frame_done(frame_done), .overflow_err(overflow_err)
  );

  bin_window_buffer_b4 #(.CH(32), .KERNEL(1), .STRIDE(1), .FRAME_LEN(4), .ADDR_W(2)) u_small (
    .clk(clk), .rst_n(rst_n), .bin_in(s_bin_in), .bin_in_val(s_val),
    .win_out(s_win_out), .win_val(s_win_val), .win_ready(s_ready),
    .win_last(s_win_last), .frame_done(s_frame_done), .overflow_err(s_ovf)
  );

  always #5 clk = ~clk;

  // Free-running cycle index used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Window w of the stream: frame w/NW, window j=w%NW covers vectors j*S .. j*S+K-1.
  function automatic logic [WW-1:0] exp_win(input int w);
    int f;
    int j;
    logic [WW-1:0] r;
    f = w / NW;
    j = w % NW;
    r = '0;
    for (int i = 0; i < K; i++) begin
      if (f * F + j * S + i < sent.size()) r[i*CH +: CH] = sent[f*F + j*S + i];
    end
    return r;
  endfunction

  // Sends n vectors (value base+k or random); the first `keep` are expected to be stored.
  task automatic drive(input int n, input int keep, input bit rnd, input int base,
                       input int idle_min, input int idle_max);
    int idle;
    for (int k = 0; k < n; k++) begin
      bin_in     = rnd ? CH'($urandom) : CH'(base + k);
      bin_in_val = 1'b1;
      if (k < keep) sent.push_back(bin_in);
      if (k == n - 1) last_wr_cyc = cyc;
      @(posedge clk); #1;
      bin_in_val = 1'b0;
      idle = $urandom_range(idle_max, idle_min);
      repeat (idle) begin
        @(posedge clk); #1;
      end
    end
  endtask

  // Accepts nwin windows; mode 0 = ready held high, mode 1 = 1 high / 3 low.
  task automatic collect(input int nwin, input int mode, input int budget);
    int w;
    int n;
    logic [WW-1:0] held;
    logic held_last;
    bit held_ok;
    w = 0;
    n = 0;
    held = '0;
    held_last = 1'b0;
    held_ok = 1'b0;
    first_val_cyc = -1;
    fd_cnt = 0;
    win_ready = (mode == 0) ? 1'b1 : (cyc % 4 == 0);
    while (w < nwin && n < budget) begin
      @(negedge clk);
      n++;
      if (frame_done) fd_cnt++;
      if (win_val && first_val_cyc < 0) first_val_cyc = cyc;
      if (win_val) begin
        if (held_ok) begin
          check("hold_data", win_out, held);
          check("hold_last", win_last, held_last);
        end
        if (win_ready) begin
          check($sformatf("win%0d", w), win_out, exp_win(w));
          check($sformatf("last%0d", w), win_last, ((w % NW) == NW - 1));
          w++;
          held_ok = 1'b0;
        end else begin
          held = win_out;
          held_last = win_last;
          held_ok = 1'b1;
        end
      end
      @(posedge clk); #1;
      win_ready = (w >= nwin) ? 1'b0 : ((mode == 0) ? 1'b1 : (cyc % 4 == 0));
    end
    check("win_count", w, nwin);
    repeat (3) begin
      @(negedge clk);
      if (frame_done) fd_cnt++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    int w;
    int sfd;
    logic [CH-1:0] sv [4];

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst_win_out", win_out, '0);
    check("rst_win_val", win_val, 1'b0);
    check("rst_win_last", win_last, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_overflow", overflow_err, 1'b0);
    check("rst_small_val", s_win_val, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single frame of k=0..63 back-to-back, ready high.
    sent.delete();
    fork
      drive(F, F, 1'b0, 0, 0, 0);
      collect(NW, 0, 2000);
    join
    check("latency_first_val", first_val_cyc - last_wr_cyc, 9);
    check("single_frame_done", fd_cnt, 1);

    // Back-pressure on a random frame.
    sent.delete();
    fork
      drive(F, F, 1'b1, 0, 0, 0);
      collect(NW, 1, 4000);
    join
    check("bp_frame_done", fd_cnt, 1);

    // Three frames tagged frame*64+k, streamed at a rate the reader sustains.
    sent.delete();
    fork
      drive(3 * F, 3 * F, 1'b0, 0, 1, 2);
      collect(3 * NW, 0, 6000);
    join
    check("pp_frame_done", fd_cnt, 3);
    check("pp_overflow", overflow_err, 1'b0);

    // Overflow: 129 vectors with the consumer stalled; the last one is dropped.
    sent.delete();
    win_ready = 1'b0;
    drive(2 * F + 1, 2 * F, 1'b1, 0, 0, 0);
    @(posedge clk); #1;
    check("ovf_set", overflow_err, 1'b1);
    check("ovf_window_waiting", win_val, 1'b1);
    collect(2 * NW, 0, 3000);
    check("ovf_frame_done", fd_cnt, 2);
    check("ovf_sticky", overflow_err, 1'b1);

    // Reset while window 10 is being offered.
    sent.delete();
    fork
      drive(F, F, 1'b1, 0, 0, 0);
      collect(10, 0, 2000);
    join
    n = 0;
    while (!win_val && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("pre_reset_val", win_val, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_win_out", win_out, '0);
    check("mid_rst_win_val", win_val, 1'b0);
    check("mid_rst_win_last", win_last, 1'b0);
    check("mid_rst_frame_done", frame_done, 1'b0);
    check("mid_rst_overflow", overflow_err, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    sent.delete();
    fork
      drive(F, F, 1'b1, 0, 0, 0);
      collect(NW, 0, 2000);
    join
    check("post_rst_frame_done", fd_cnt, 1);

    // Boundary configuration: each window is a single input vector.
    s_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sv[k] = CH'($urandom);
      s_bin_in = sv[k];
      s_val = 1'b1;
      @(posedge clk); #1;
    end
    s_val = 1'b0;
    s_ready = 1'b1;
    w = 0;
    n = 0;
    sfd = 0;
    while (w < 4 && n < 200) begin
      @(negedge clk);
      n++;
      if (s_frame_done) sfd++;
      if (s_win_val && s_ready) begin
        check($sformatf("small_win%0d", w), s_win_out, sv[w]);
        check($sformatf("small_last%0d", w), s_win_last, (w == 3));
        w++;
      end
      @(posedge clk); #1;
    end
    check("small_count", w, 4);
    repeat (3) begin
      @(negedge clk);
      if (s_frame_done) sfd++;
    end
    check("small_frame_done", sfd, 1);
    check("small_overflow", s_ovf, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
